gpio_bcd2bin: RTL and testbench

- Sequential reverse-double-dabble converter: takes a packed 8-digit BCD word in the same layout the CPU drives onto gpio_out, and returns its binary value.
- Sits beside the gpio block. Self-check hardware and firmware use it to read a displayed decimal value back as a number.
- Uses a start/busy/done handshake and a single shift datapath: one bit per clock.

---
 rtl/gpio_bcd2bin.sv | 122 ++++++++++++
 tb/tb_gpio_bcd2bin.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bcd2bin.sv
// rtl/gpio_bcd2bin.sv - sequential reverse-double-dabble BCD to binary converter
// Optional GPIO_BCD2BIN_ERRCNT_EN adds an 8-bit saturating count of conversions that ended in error.
module gpio_bcd2bin #(
    parameter int DIGITS = 8,
    parameter int BIN_W  = 27
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
`ifdef GPIO_BCD2BIN_ERRCNT_EN
    output logic [7:0]            err_cnt,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIN
    } state_t;

    state_t             state;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BIN_W-1:0]   bin_reg;
    logic [CNT_W-1:0]   cnt;
    logic               bad_reg;

    logic               bad_digit;
    logic [BCD_W-1:0]   bcd_shift;
    logic [BCD_W-1:0]   bcd_next;
    logic [BIN_W-1:0]   bin_next;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // One reverse-dabble step: shift right, then pull every nibble >= 8 back by 3.
    always_comb begin
        {bcd_shift, bin_next} = {bcd_reg, bin_reg} >> 1;
        bcd_next = bcd_shift;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_shift[4*i +: 4] >= 4'd8) begin
                bcd_next[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            bin_out <= '0;
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
            bad_reg <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bcd_reg <= bcd_in;
                        bin_reg <= '0;
                        cnt     <= CNT_W'(BIN_W);
                        err     <= 1'b0;
                        bad_reg <= bad_digit;
                        if (bad_digit) begin
                            state <= FIN;
                        end else begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    bcd_reg <= bcd_next;
                    bin_reg <= bin_next;
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FIN;
                        busy  <= 1'b0;
                    end
                end
                FIN: begin
                    bin_out <= bad_reg ? '0 : bin_reg;
                    err     <= bad_reg;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GPIO_BCD2BIN_ERRCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= 8'd0;
        end else if (state == FIN && bad_reg && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gpio_bcd2bin.sv
// tb/tb_gpio_bcd2bin.sv - self-checking bench for gpio_bcd2bin
// Honours GPIO_BCD2BIN_ERRCNT_EN to connect and check err_cnt.
module tb_gpio_bcd2bin;

    localparam int DIGITS = 8;
    localparam int BIN_W  = 27;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [4*DIGITS-1:0]  bcd_in;
    logic                 busy;
    logic                 done;
    logic [BIN_W-1:0]     bin_out;
    logic                 err;
`ifdef GPIO_BCD2BIN_ERRCNT_EN
    logic [7:0]           err_cnt;
`endif

    int errors = 0;
    int checks = 0;

    gpio_bcd2bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
`ifdef GPIO_BCD2BIN_ERRCNT_EN
        .err_cnt (err_cnt),
`endif
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Decimal meaning of a packed BCD word, straight from the digit weights.
    function automatic void decode(input logic [31:0] b, output bit ok, output int v);
        logic [3:0] d;
        ok = 1'b1;
        v  = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = b[4*i +: 4];
            if (d > 4'd9) ok = 1'b0;
            v = v * 10 + int'(d);
        end
    endfunction

    // Reference model: outputs as a function of edges elapsed since the accepted start.
    bit   m_active;
    int   m_age;
    int   m_done_off;
    bit   m_ok;
    int   m_val;
    bit   exp_busy;
    bit   exp_done;
    int   exp_bin;
    bit   exp_err;
    int   exp_cnt;

    always @(posedge clk or negedge rst) begin : model
        bit  act;
        int  age;
        int  off;
        bit  ok;
        int  val;
        bit  e_err;
        int  e_bin;
        int  e_cnt;
        if (!rst) begin
            m_active <= 1'b0;
            m_age    <= 0;
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
            exp_bin  <= 0;
            exp_err  <= 1'b0;
            exp_cnt  <= 0;
        end else begin
            act   = m_active;
            age   = m_age;
            off   = m_done_off;
            ok    = m_ok;
            val   = m_val;
            e_err = exp_err;
            e_bin = exp_bin;
            e_cnt = exp_cnt;
            if (act) age = age + 1;
            if (act && age > off) act = 1'b0;
            if (!act && start) begin
                act = 1'b1;
                age = 0;
                decode(bcd_in, ok, val);
                off   = ok ? BIN_W + 1 : 1;
                e_err = 1'b0;
            end
            if (act && age == off) begin
                e_bin = ok ? val : 0;
                e_err = !ok;
                if (!ok && e_cnt < 255) e_cnt = e_cnt + 1;
            end
            m_active   <= act;
            m_age      <= age;
            m_done_off <= off;
            m_ok       <= ok;
            m_val      <= val;
            exp_busy   <= act && ok && age < BIN_W;
            exp_done   <= act && age == off;
            exp_bin    <= e_bin;
            exp_err    <= e_err;
            exp_cnt    <= e_cnt;
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        chk("bin_out", bin_out, exp_bin);
        chk("err", err, exp_err);
        checks++;
        if (busy && done) begin
            errors++;
            $display("FAIL busy_done_overlap at %0t: got busy=1 done=1, expected not both", $time);
        end
`ifdef GPIO_BCD2BIN_ERRCNT_EN
        chk("err_cnt", err_cnt, exp_cnt);
`endif
    end

    // Issues one start pulse and returns edges from the accepted edge to done.
    task automatic run_conv(input logic [31:0] b, output int lat);
        @(posedge clk); #2;
        bcd_in = b;
        start  = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) break;
        end
    endtask

    int lat;
    int ndone;
    int t_cycle;
    int t_prev;

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        bcd_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_bin", bin_out, 0);
        #1 rst = 1'b1;

        run_conv(32'h0026_2143, lat);
        chk("lat_262143", lat, 28);
        chk("bin_262143", bin_out, 27'h003FFFF);
        chk("err_262143", err, 1'b0);

        run_conv(32'h9999_9999, lat);
        chk("bin_max", bin_out, 27'd99999999);
        run_conv(32'h0000_0000, lat);
        chk("bin_zero", bin_out, 0);
        chk("lat_zero", lat, 28);

        run_conv(32'h000A_0001, lat);
        chk("lat_bad", lat, 1);
        chk("err_bad", err, 1'b1);
        chk("bin_bad", bin_out, 0);
`ifdef GPIO_BCD2BIN_ERRCNT_EN
        chk("err_cnt_bad", err_cnt, 8'd1);
`endif

        @(posedge clk); #2;
        bcd_in = 32'h1234_5678;
        start  = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        bcd_in = 32'h0000_0042;
        start  = 1'b1;
        @(posedge clk); #2;
        start  = 1'b0;
        bcd_in = '0;
        ndone  = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("ignored_start_dones", ndone, 1);
        chk("bin_12345678", bin_out, 27'h0BC614E);

        @(posedge clk); #2;
        bcd_in = 32'h8765_4321;
        start  = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_bin", bin_out, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        ndone = 0;
        repeat (35) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_conv(32'h0000_0100, lat);
        chk("bin_100", bin_out, 100);

        @(posedge clk); #2;
        bcd_in  = 32'h0000_0009;
        start   = 1'b1;
        ndone   = 0;
        t_cycle = 0;
        t_prev  = 0;
        while (ndone < 3 && t_cycle < 200) begin
            @(negedge clk);
            t_cycle++;
            if (done) begin
                ndone++;
                chk("bin_9", bin_out, 9);
                if (ndone > 1) chk("b2b_period", t_cycle - t_prev, 29);
                t_prev = t_cycle;
                if (ndone == 3) start = 1'b0;
            end
        end
        chk("b2b_count", ndone, 3);
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
